proc_control_unit: RTL and testbench

Multi-cycle control FSM for the 16-bit datapath. It fetches an instruction word from `din`, then sequences the shared-bus 8-to-1 select, the register load enables, the ALU operand/result register loads and the add/sub control. It sits directly upstream of the 16-bit 8-to-1 bus multiplexer and drives its select input every cycle. The datapath wires mux inputs as in0–in5 = R0–R5, in6 = G (ALU result), in7 = `din` (immediate).

---
 rtl/proc_control_if.sv | 26 ++
 rtl/proc_control_unit.sv | 117 +++++++++++
 tb/tb_proc_control_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/proc_control_if.sv
// Handshake/control bundle between the instruction source and the control unit.
// The slave side is the control unit; the master side supplies run/din and observes controls.
interface proc_control_if #(
  parameter int N = 16
);
  logic         run;
  logic [N-1:0] din;
  logic [2:0]   bus_sel;
  logic [5:0]   r_load;
  logic         ir_load;
  logic         a_load;
  logic         g_load;
  logic         alu_sub;
  logic         done;
  logic         illegal;

  modport master (
    output run, din,
    input  bus_sel, r_load, ir_load, a_load, g_load, alu_sub, done, illegal
  );

  modport slave (
    input  run, din,
    output bus_sel, r_load, ir_load, a_load, g_load, alu_sub, done, illegal
  );
endinterface

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for the 16-bit datapath: fetches an instruction word and
// sequences bus select, register loads and ALU control over T0..T3.
module proc_control_unit #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  proc_control_if.slave  bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] SEL_G   = 3'd6;
  localparam logic [2:0] SEL_DIN = 3'd7;

  state_t       state_q, state_d;
  logic [N-1:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       ir_unused;

  logic [2:0] bus_sel;
  logic [5:0] r_load;
  logic       ir_load, a_load, g_load, alu_sub, done, illegal;

  assign op        = ir_q[N-1 -: 3];
  assign rx        = ir_q[N-4 -: 3];
  assign ry        = ir_q[N-7 -: 3];
  assign ir_unused = ^ir_q[N-10:0];

  // Destinations 6 and 7 (G, din) are not writable registers, so they decode to no enable.
  function automatic logic [5:0] dest_onehot(input logic [2:0] r);
    logic [5:0] oh;
    oh = (r < 3'd6) ? (6'd1 << r) : 6'd0;
    return oh;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    bus_sel = 3'b000;
    r_load  = 6'b000000;
    ir_load = 1'b0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    alu_sub = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      T0: begin
        ir_load = bus.run & ~rst;
        if (bus.run) begin
          ir_d    = bus.din;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          3'b000: begin
            bus_sel = ry;
            r_load  = dest_onehot(rx);
            done    = 1'b1;
            state_d = T0;
          end
          3'b001: begin
            bus_sel = SEL_DIN;
            r_load  = dest_onehot(rx);
            done    = 1'b1;
            state_d = T0;
          end
          3'b010, 3'b011: begin
            bus_sel = rx;
            a_load  = 1'b1;
            state_d = T2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        bus_sel = ry;
        g_load  = 1'b1;
        alu_sub = op[0];
        state_d = T3;
      end
      T3: begin
        bus_sel = SEL_G;
        r_load  = dest_onehot(rx);
        done    = 1'b1;
        state_d = T0;
      end
    endcase
  end

  assign bus.bus_sel = bus_sel;
  assign bus.r_load  = r_load;
  assign bus.ir_load = ir_load;
  assign bus.a_load  = a_load;
  assign bus.g_load  = g_load;
  assign bus.alu_sub = alu_sub;
  assign bus.done    = done;
  assign bus.illegal = illegal;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: an instruction-level model expands each fetched
// word into its expected cycle sequence; a negedge monitor compares every cycle.
module tb_proc_control_unit;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic [5:0] r_load;
    logic       ir_load;
    logic       a_load;
    logic       g_load;
    logic       alu_sub;
    logic       done;
    logic       illegal;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_control_if #(.N(16)) bus_if();
  proc_control_unit #(.N(16)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  rec_t exp_q[$];
  rec_t pend_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  function automatic rec_t actual();
    rec_t a;
    a = '{bus_sel: bus_if.bus_sel, r_load: bus_if.r_load, ir_load: bus_if.ir_load,
          a_load: bus_if.a_load, g_load: bus_if.g_load, alu_sub: bus_if.alu_sub,
          done: bus_if.done, illegal: bus_if.illegal};
    return a;
  endfunction

  function automatic rec_t mk(input int bs, input logic [5:0] rl, input bit il, input bit al,
                              input bit gl, input bit sb, input bit dn, input bit ill);
    rec_t r;
    r = '{bus_sel: 3'(bs), r_load: rl, ir_load: il, a_load: al, g_load: gl,
          alu_sub: sb, done: dn, illegal: ill};
    return r;
  endfunction

  // Instruction-level reference: fetch cycle followed by the instruction's control steps.
  task automatic plan(input logic [15:0] w);
    int op, rx, ry;
    logic [5:0] dest;
    op   = int'(w[15:13]);
    rx   = int'(w[12:10]);
    ry   = int'(w[9:7]);
    dest = (rx < 6) ? 6'(1 << rx) : 6'd0;
    pend_q.push_back(mk(0, 6'd0, 1, 0, 0, 0, 0, 0));
    if (op == 0) begin
      pend_q.push_back(mk(ry, dest, 0, 0, 0, 0, 1, 0));
    end else if (op == 1) begin
      pend_q.push_back(mk(7, dest, 0, 0, 0, 0, 1, 0));
    end else if (op == 2 || op == 3) begin
      pend_q.push_back(mk(rx, 6'd0, 0, 1, 0, 0, 0, 0));
      pend_q.push_back(mk(ry, 6'd0, 0, 0, 1, op == 3, 0, 0));
      pend_q.push_back(mk(6, dest, 0, 0, 0, 0, 1, 0));
    end else begin
      pend_q.push_back(mk(0, 6'd0, 0, 0, 0, 0, 1, 1));
    end
  endtask

  task automatic tick(input bit want, input logic [15:0] w);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (pend_q.size() == 0) begin
      bus_if.run = want;
      bus_if.din = w;
      if (want) plan(w);
      else pend_q.push_back('0);
    end else begin
      bus_if.run = 1'($urandom_range(0, 1));
      bus_if.din = 16'($urandom);
    end
    exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic issue(input logic [15:0] w);
    tick(1'b1, w);
    while (pend_q.size() != 0) tick(1'b0, 16'h0000);
  endtask

  task automatic reset_pulse(input int cycles);
    rec_t a;
    @(posedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    bus_if.run = 1'b1;
    pend_q.delete();
    exp_q.push_back('0);
    #1;
    a = actual();
    n_tests++;
    if (a !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h required=0", a);
    end
    for (int i = 1; i < cycles; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back('0);
    end
  endtask

  always @(negedge clk) begin
    rec_t a, e;
    if (mon_en) begin
      a = actual();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: outputs=%h with no expectation", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t: got sel=%0d rl=%b ir=%b a=%b g=%b sub=%b dn=%b ill=%b, want sel=%0d rl=%b ir=%b a=%b g=%b sub=%b dn=%b ill=%b",
                   $time, a.bus_sel, a.r_load, a.ir_load, a.a_load, a.g_load, a.alu_sub, a.done, a.illegal,
                   e.bus_sel, e.r_load, e.ir_load, e.a_load, e.g_load, e.alu_sub, e.done, e.illegal);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t a;
    rst = 1'b1;
    bus_if.run = 1'b1;
    bus_if.din = 16'h2000;
    #1;
    a = actual();
    n_tests++;
    if (a !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%h required=0", a);
    end
    @(negedge clk);
    #1;
    mon_en = 1'b1;

    issue(16'h2000);
    issue(16'h4500);
    issue(16'h6500);
    issue(16'h1D80);
    issue(16'hE000);
    tick(1'b0, 16'h0000);
    issue(16'h0A00);
    issue(16'h4500);
    issue(16'h2400);
    reset_pulse(2);
    issue(16'h6500);
    tick(1'b1, 16'h4500);
    tick(1'b0, 16'h0000);
    reset_pulse(1);
    issue(16'h0580);
    issue(16'h5F80);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse(int'($urandom_range(1, 2)));
      else tick($urandom_range(0, 3) != 0, 16'($urandom));
    end
    while (pend_q.size() != 0) tick(1'b0, 16'h0000);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
